// File: rtl/vc_writeback_buffer.sv
// vc_writeback_buffer
// -------------------
// Write-back buffer that sits directly downstream of the victim cache datapath.
// The victim cache evicts dirty lines into this buffer. The buffer holds them in
// FIFO order and writes them to physical memory one line at a time. While a line
// waits here, a lookup on its address hits it, so a miss never reads stale memory.
//
// Ports
//   i_clk             clock; all state updates on the rising edge
//   i_reset           synchronous, active-high reset
//   i_evict_valid     victim cache presents a dirty line
//   i_evict_address   line address of the evicted line
//   i_evict_data      evicted line data
//   o_evict_ready     line accepted this cycle when i_evict_valid & o_evict_ready
//   i_lookup_address  line address probed by the miss path
//   o_lookup_hit      combinational: a valid entry matches i_lookup_address
//   o_lookup_data     data of the newest matching entry; 0 when there is no hit
//   o_pmem_write      memory write request, held until i_pmem_resp
//   o_pmem_address    {head line address, 4'b0}
//   o_pmem_wdata      head entry data
//   i_pmem_resp       memory finished the write (single-cycle pulse)
//   o_empty           no valid entries
//   o_full            count == DEPTH
//   o_count           number of valid entries
module vc_writeback_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 128
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_evict_valid,
  input  logic [ADDR_W-1:0]        i_evict_address,
  input  logic [DATA_W-1:0]        i_evict_data,
  output logic                     o_evict_ready,
  input  logic [ADDR_W-1:0]        i_lookup_address,
  output logic                     o_lookup_hit,
  output logic [DATA_W-1:0]        o_lookup_data,
  output logic                     o_pmem_write,
  output logic [ADDR_W+3:0]        o_pmem_address,
  output logic [DATA_W-1:0]        o_pmem_wdata,
  input  logic                     i_pmem_resp,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    StIdle,
    StWrite
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              r_state;
  logic                r_pmem_write;

  logic [DEPTH-1:0]    r_valid;
  logic [ADDR_W-1:0]   r_addr [DEPTH];
  logic [DATA_W-1:0]   r_data [DEPTH];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;

  // ---------------------------------------------------------------------------
  // Combinational search
  // ---------------------------------------------------------------------------
  logic                w_inflight;
  logic                w_coal_match;
  logic [PTR_W-1:0]    w_coal_idx;
  logic                w_look_hit;
  logic [PTR_W-1:0]    w_look_idx;
  logic [PTR_W-1:0]    w_scan_idx;

  logic                w_accept;
  logic                w_alloc;
  logic                w_coalesce;
  logic                w_pop;

  assign w_inflight = (r_state == StWrite);

  // Walk the entries from oldest (head) to newest. A later match overrides an
  // earlier one, so each result ends up on the newest matching entry. The
  // in-flight head is excluded from coalescing. Its data is already on the bus,
  // so a rewrite of the same line gets a fresh entry behind it.
  always_comb begin
    w_coal_match = 1'b0;
    w_coal_idx   = '0;
    w_look_hit   = 1'b0;
    w_look_idx   = '0;
    w_scan_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan_idx = r_head + PTR_W'(k);
      if (r_valid[w_scan_idx] && (r_addr[w_scan_idx] == i_evict_address) &&
          !(w_inflight && (w_scan_idx == r_head))) begin
        w_coal_match = 1'b1;
        w_coal_idx   = w_scan_idx;
      end
      if (r_valid[w_scan_idx] && (r_addr[w_scan_idx] == i_lookup_address)) begin
        w_look_hit = 1'b1;
        w_look_idx = w_scan_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status and handshake
  // ---------------------------------------------------------------------------
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

  // A coalescing eviction needs no new slot, so it is accepted even when full.
  assign o_evict_ready = !o_full || w_coal_match;

  assign w_accept   = i_evict_valid && o_evict_ready;
  assign w_alloc    = w_accept && !w_coal_match;
  assign w_coalesce = w_accept && w_coal_match;
  assign w_pop      = w_inflight && i_pmem_resp;

  assign o_lookup_hit  = w_look_hit;
  assign o_lookup_data = w_look_hit ? r_data[w_look_idx] : '0;

  assign o_pmem_write   = r_pmem_write;
  assign o_pmem_address = {r_addr[r_head], 4'b0000};
  assign o_pmem_wdata   = r_data[r_head];

  // ---------------------------------------------------------------------------
  // Entry storage, pointers and occupancy
  // ---------------------------------------------------------------------------
  // A pop and an allocation never target the same slot. An allocation needs
  // count < DEPTH, so tail points at a free slot. A pop needs count >= 1, so
  // head points at an occupied slot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= i_evict_address;
        r_data[r_tail]  <= i_evict_data;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_coalesce) begin
        r_data[w_coal_idx] <= i_evict_data;
      end
      unique case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  // The FSM passes through IDLE for one cycle after every response. This is the
  // bubble between consecutive memory writes. A response that arrives in IDLE
  // has no effect.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_pmem_write <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!o_empty) begin
            r_state      <= StWrite;
            r_pmem_write <= 1'b1;
          end
        end
        StWrite: begin
          if (i_pmem_resp) begin
            r_state      <= StIdle;
            r_pmem_write <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
